fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and helpers for the FIFO write arbiter
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker, first valid at or after ptr
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]    valid,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] idx,
  output logic                found
);

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid[(int'(ptr) + i) % N_REQ]) begin
        idx   = ID_WIDTH'((int'(ptr) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ID_WIDTH   = clog2(N_REQ),
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int BURST_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [ADDR_WIDTH:0]         fifo_count,
  input  logic                        fifo_full,
  output logic                        push,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        busy,
  output logic                        err_ovf
);

  localparam int BCW = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;

  logic                  state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [BCW-1:0]        beat_cnt;
  logic [ADDR_WIDTH+1:0] occ;
  logic                  space_ok;
  logic                  cur_valid;
  logic                  xfer;
  logic                  last_beat;
  logic                  release_now;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] cur_data;

  rr_pick #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The word sitting in the push register has not landed in fifo_count yet.
  assign occ       = {1'b0, fifo_count} + {{(ADDR_WIDTH+1){1'b0}}, push};
  assign space_ok  = occ < (ADDR_WIDTH+2)'(RAM_DEPTH);
  assign cur_valid = req_valid[grant_id];
  assign cur_data  = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign xfer      = (state == ST_GRANT) && cur_valid && space_ok;
  assign last_beat = (beat_cnt == BCW'(BURST_LEN - 1));
  assign release_now = (state == ST_GRANT) && ((xfer && last_beat) || !cur_valid);
  assign next_ptr  = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
  assign busy      = (state == ST_GRANT);

  always_comb begin
    req_ready = '0;
    if (state == ST_GRANT) req_ready[grant_id] = space_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      push     <= 1'b0;
      data_in  <= '0;
      grant_id <= '0;
      err_ovf  <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      push <= xfer;
      if (xfer) data_in <= cur_data;
      if (push && fifo_full) err_ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        default: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if (release_now) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [4:0]      fifo_count;
  logic            fifo_full;
  logic            push;
  logic [DW-1:0]   data_in;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_ovf;

  fifo_wr_arbiter #(
    .N_REQ(4), .ID_WIDTH(2), .DATA_WIDTH(64), .ADDR_WIDTH(4), .RAM_DEPTH(16), .BURST_LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_count(fifo_count), .fifo_full(fifo_full),
    .push(push), .data_in(data_in), .grant_id(grant_id), .busy(busy), .err_ovf(err_ovf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int npush = 0;

  logic [63:0] mem [N][8];
  int head [N];
  int tail [N];
  int lim  [N];

  logic [63:0] exp_q[$];
  int          grant_q[$];
  int          lat_q[$];
  logic        busy_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (head[i] < tail[i]) && (head[i] < lim[i]);
      req_data[i*DW +: DW] = mem[i][head[i] % 8];
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
      lim[i]  = 99;
      for (int k = 0; k < 8; k++) mem[i][k] = '0;
    end
  endtask

  task automatic load(input int r, input logic [63:0] w);
    mem[r][tail[r]] = w;
    tail[r]++;
  endtask

  // Producer model: sample the handshake just before the edge, advance just after it.
  initial begin
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      #4;
      hs = req_valid & req_ready & {N{reset}};
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (hs[i]) begin
          head[i]++;
          lat_q.push_back(cyc);
        end
      apply();
    end
  end

  // Monitor: every push must match the next expected word, one cycle after its handshake.
  always @(negedge clk) begin
    logic [63:0] e;
    int l;
    int g;
    if (push) begin
      npush++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL push_extra: got %0h expected no push", data_in);
      end else begin
        e = exp_q.pop_front();
        if (data_in !== e) begin
          errors++;
          $display("FAIL push_data: got %0h expected %0h", data_in, e);
        end
      end
      if (lat_q.size() != 0) begin
        l = lat_q.pop_front();
        checks++;
        if (l != cyc) begin
          errors++;
          $display("FAIL push_latency: push in cycle %0d expected %0d", cyc, l);
        end
      end
    end
    if (busy && !busy_q) begin
      checks++;
      if (grant_q.size() == 0) begin
        errors++;
        $display("FAIL grant_extra: got grant %0d expected none", grant_id);
      end else begin
        g = grant_q.pop_front();
        if (int'(grant_id) != g) begin
          errors++;
          $display("FAIL grant_order: got %0d expected %0d", grant_id, g);
        end
      end
    end
    busy_q = busy;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    fifo_count = '0;
    fifo_full = 1'b0;
    clear_src();
    @(negedge clk);
    lat_q.delete();
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && grant_q.size() == 0 && !busy && !push && req_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d words left expected 0", nm, exp_q.size());
      exp_q.delete();
      grant_q.delete();
    end
  endtask

  task automatic wait_push(input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (push) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no push expected push", nm);
    end
  endtask

  initial begin
    bit ok;
    int p0;
    reset = 1'b0;
    fifo_count = '0;
    fifo_full = 1'b0;
    clear_src();
    apply();
    repeat (2) @(negedge clk);
    chk("rst_push", push, 0);
    chk("rst_data", data_in, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_ovf, 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b1;

    // 1: single requester, 6 words split into 4 + 2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      load(1, 64'h10 + 64'(k));
      exp_q.push_back(64'h10 + 64'(k));
    end
    grant_q.push_back(1);
    grant_q.push_back(1);
    @(negedge clk);
    chk("s1_busy_pre", busy, 0);
    @(negedge clk);
    chk("s1_busy", busy, 1);
    chk("s1_grant", grant_id, 1);
    wait_drain("s1");

    // 2: all requesters busy, fair rotation
    do_reset();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 4; k++) begin
        load(r, 64'hA000 + 64'(r*16 + k));
        exp_q.push_back(64'hA000 + 64'(r*16 + k));
      end
    for (int k = 4; k < 8; k++) begin
      load(0, 64'hA000 + 64'(k));
      exp_q.push_back(64'hA000 + 64'(k));
    end
    grant_q = '{0, 1, 2, 3, 0};
    wait_drain("s2");

    // 3: one slot left, the in-flight word must close it
    do_reset();
    fifo_count = 5'd15;
    for (int k = 0; k < 3; k++) begin
      load(0, 64'hB0 + 64'(k));
      exp_q.push_back(64'hB0 + 64'(k));
    end
    grant_q.push_back(0);
    p0 = npush;
    wait_push("s3_first");
    chk("s3_ready_inflight", req_ready, 0);
    @(negedge clk);
    fifo_count = 5'd16;
    fifo_full = 1'b1;
    repeat (4) @(negedge clk);
    chk("s3_ready_stall", req_ready, 0);
    chk("s3_busy_stall", busy, 1);
    chk("s3_one_beat", 64'(npush - p0), 1);
    fifo_count = 5'd12;
    fifo_full = 1'b0;
    wait_drain("s3");
    chk("s3_no_err", err_ovf, 0);

    // 4: requester 2 drops valid after 2 beats, requester 3 goes next
    do_reset();
    for (int k = 0; k < 4; k++) load(2, 64'h20 + 64'(k));
    lim[2] = 2;
    load(3, 64'h30);
    load(3, 64'h31);
    exp_q = '{64'h20, 64'h21, 64'h30, 64'h31, 64'h22, 64'h23};
    grant_q = '{2, 3, 2};
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (busy && grant_id == 2'd2 && !req_valid[2]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("s4_dropped", 64'(ok), 1);
    lim[2] = 4;
    wait_drain("s4");

    // 5: reset mid-burst restarts arbitration from requester 0
    do_reset();
    load(0, 64'hD0);
    exp_q.push_back(64'hD0);
    grant_q.push_back(0);
    wait_drain("s5a");
    for (int k = 0; k < 4; k++) load(1, 64'hE0 + 64'(k));
    exp_q.push_back(64'hE0);
    grant_q.push_back(1);
    wait_push("s5_inflight");
    reset = 1'b0;
    load(0, 64'hD1);
    load(0, 64'hD2);
    @(negedge clk);
    chk("s5_push", push, 0);
    chk("s5_busy", busy, 0);
    chk("s5_grant", grant_id, 0);
    reset = 1'b1;
    exp_q = '{64'hD1, 64'hD2, 64'hE1, 64'hE2, 64'hE3};
    grant_q = '{0, 1};
    wait_drain("s5");

    // 6: push while full raises a sticky error
    do_reset();
    fifo_count = 5'd10;
    load(0, 64'hF0);
    load(0, 64'hF1);
    exp_q = '{64'hF0, 64'hF1};
    grant_q.push_back(0);
    wait_push("s6_inflight");
    chk("s6_err_before", err_ovf, 0);
    fifo_full = 1'b1;
    @(negedge clk);
    chk("s6_err_set", err_ovf, 1);
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("s6_err_sticky", err_ovf, 1);
    wait_drain("s6");
    do_reset();
    chk("s6_err_cleared", err_ovf, 0);

    chk("end_exp_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
